// File: rtl/mux_src_arbiter.sv
// mux_src_arbiter
//   Round-robin arbiter and sequencer for the shared output mux of the HACKDAC
//   datapath. One source is granted at a time and its data is burst onto a
//   valid/ready output for at most BURST_LEN beats. The secure source
//   (SECURE_IDX) only reaches out_data while priv_mode is high. out_data is
//   zero whenever no legal transfer is being presented.
//
//   Optional feature: define MUX_ARB_TIMEOUT_EN to release a grant that has
//   been stalled (out_valid & !out_ready) for TIMEOUT consecutive cycles.
//
// Ports
//   clk          in   1        clock, rising edge
//   rst          in   1        synchronous active-high reset
//   req          in   N_REQ    per-source level request
//   data_in      in   N_REQ*W  source i on data_in[i*W +: W]
//   priv_mode    in   1        privileged mode, enables SECURE_IDX
//   out_ready    in   1        downstream accept
//   gnt          out  N_REQ    registered one-hot grant
//   out_data     out  W        selected data, 0 when out_valid=0
//   out_valid    out  1        transfer presented
//   blocked_err  out  1        pulse: secure request refused in IDLE
//   timeout_err  out  1        pulse: grant released after stall timeout
module mux_src_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned W          = 128,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned SECURE_IDX = 3,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] data_in,
  input  logic               priv_mode,
  input  logic               out_ready,
  output logic [N_REQ-1:0]   gnt,
  output logic [W-1:0]       out_data,
  output logic               out_valid,
  output logic               blocked_err,
  output logic               timeout_err
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [3:0]       beat_cnt;
  logic [3:0]       beat_nxt;
  logic [N_REQ-1:0] elig;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [W-1:0]     sel_data;
  logic             xfer;
  logic             stall;
  logic             stall_release;
  logic             release_now;

  always_comb begin
    elig = req;
    if (!priv_mode) elig[SECURE_IDX] = 1'b0;
  end

  // First eligible source scanning upward from rr_ptr+1, wrapping.
  always_comb begin
    logic [IW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IW'((32'(rr_ptr) + k) % N_REQ);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // gnt is one-hot, so the owner's data is selected directly from it.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_data = data_in[i*W +: W];
    end
  end

  // Eligibility is re-evaluated every cycle so a priv_mode drop blanks the
  // secure owner's data in the same cycle, before the grant is withdrawn.
  assign out_valid = (state == GRANT) && ((elig & gnt) != '0);
  assign out_data  = out_valid ? sel_data : '0;
  assign xfer      = out_valid & out_ready;
  assign stall     = out_valid & ~out_ready;
  assign beat_nxt  = beat_cnt + 4'd1;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_cnt;

  assign stall_release = (state == GRANT) && stall && (stall_cnt == SW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= stall_release;
      if (state != GRANT || !stall || release_now) stall_cnt <= '0;
      else                                         stall_cnt <= stall_cnt + SW'(1);
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign stall_release  = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    release_now = 1'b0;
    if (state == GRANT) begin
      release_now = (xfer && (beat_nxt == 4'(BURST_LEN)))
                 || ((req & gnt) == '0)
                 || (gnt[SECURE_IDX] && !priv_mode)
                 || stall_release;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      rr_ptr      <= IW'(N_REQ - 1);
      beat_cnt    <= '0;
      blocked_err <= 1'b0;
    end else begin
      blocked_err <= 1'b0;
      case (state)
        IDLE: begin
          blocked_err <= req[SECURE_IDX] & ~priv_mode;
          if (win_found) begin
            state    <= GRANT;
            gnt      <= N_REQ'(1) << win_idx;
            rr_ptr   <= win_idx;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          // rr_ptr already holds the owner, so a release (including a
          // timeout) naturally starts the next scan after it.
          if (release_now) begin
            state    <= IDLE;
            gnt      <= '0;
            beat_cnt <= '0;
          end else if (xfer) begin
            beat_cnt <= beat_nxt;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_src_arbiter.sv
module tb_mux_src_arbiter;

  localparam int N   = 4;
  localparam int W   = 128;
  localparam int BL  = 4;
  localparam int S   = 3;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   data_in;
  logic             priv_mode;
  logic             out_ready;
  logic [N-1:0]     gnt;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             blocked_err;
  logic             timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the mux, beats done, last winner, stall run.
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = N - 1;
  int m_stall = 0;
  bit m_blk   = 1'b0;
  bit m_tmo   = 1'b0;

  mux_src_arbiter #(
    .N_REQ(N), .W(W), .BURST_LEN(BL), .SECURE_IDX(S), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .priv_mode(priv_mode), .out_ready(out_ready), .gnt(gnt),
    .out_data(out_data), .out_valid(out_valid),
    .blocked_err(blocked_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic bit el(int i, logic [N-1:0] rq, bit pv);
    return rq[i] && (i != S || pv);
  endfunction

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance the model to
  // what the design must hold after the next rising edge.
  task automatic step(input bit r, input logic [N-1:0] rq, input bit pv, input bit rdy);
    logic [N-1:0] e_gnt;
    logic [W-1:0] e_data;
    bit           e_valid;
    bit           rel;
    @(negedge clk);
    rst       = r;
    req       = rq;
    priv_mode = pv;
    out_ready = rdy;
    for (int i = 0; i < N; i++)
      data_in[i*W +: W] = {$urandom, $urandom, $urandom, $urandom};
    #1;
    e_gnt   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e_valid = (m_owner >= 0) && el(m_owner, rq, pv);
    e_data  = e_valid ? data_in[m_owner*W +: W] : '0;
    check("gnt",         W'(gnt),         W'(e_gnt));
    check("out_valid",   W'(out_valid),   W'(e_valid));
    check("out_data",    out_data,        e_data);
    check("blocked_err", W'(blocked_err), W'(m_blk));
    check("timeout_err", W'(timeout_err), W'(m_tmo));

    if (r) begin
      m_owner = -1; m_beats = 0; m_last = N - 1; m_stall = 0;
      m_blk = 1'b0; m_tmo = 1'b0;
    end else if (m_owner < 0) begin
      m_tmo = 1'b0;
      m_blk = rq[S] && !pv;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && el(c, rq, pv)) begin
          m_owner = c; m_last = c; m_beats = 0; m_stall = 0;
        end
      end
    end else begin
      m_blk = 1'b0;
      m_tmo = 1'b0;
      rel   = 1'b0;
      if (e_valid && rdy) begin
        m_beats++;
        m_stall = 0;
        if (m_beats == BL) rel = 1'b1;
      end
      if (!rq[m_owner] || (m_owner == S && !pv)) rel = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
      if (e_valid && !rdy) begin
        if (m_stall == TMO - 1) begin
          rel = 1'b1;
          m_tmo = 1'b1;
        end else begin
          m_stall++;
        end
      end
`endif
      if (rel) begin
        m_owner = -1; m_beats = 0; m_stall = 0;
      end
    end
  endtask

  initial begin
    logic [N-1:0] rq;
    bit           pv;
    rst = 1'b1; req = '0; priv_mode = 1'b0; out_ready = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);

    // Reset values, then a lone requester 0: burst, bubble, re-grant.
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    repeat (12) step(1'b0, 4'b0001, 1'b0, 1'b1);

    // Three requesters rotate 0,1,2,0 with full bursts.
    repeat (22) step(1'b0, 4'b0111, 1'b0, 1'b1);

    // Secure source refused without privilege, granted with it, then
    // privilege drops mid-burst.
    repeat (2) step(1'b0, 4'b0000, 1'b0, 1'b1);
    repeat (4) step(1'b0, 4'b1000, 1'b0, 1'b1);
    repeat (3) step(1'b0, 4'b1000, 1'b1, 1'b1);
    repeat (3) step(1'b0, 4'b1000, 1'b0, 1'b1);

    // Owner drops its request mid-burst; next eligible takes over.
    repeat (2) step(1'b0, 4'b0000, 1'b0, 1'b1);
    repeat (4) step(1'b0, 4'b0110, 1'b0, 1'b1);
    repeat (4) step(1'b0, 4'b0100, 1'b0, 1'b1);

    // Long stall: released on timeout when enabled, held otherwise.
    repeat (2) step(1'b0, 4'b0000, 1'b0, 1'b1);
    repeat (24) step(1'b0, 4'b0001, 1'b0, 1'b0);
    repeat (3) step(1'b0, 4'b0001, 1'b0, 1'b1);

    // Reset in the middle of a burst.
    repeat (2) step(1'b0, 4'b0010, 1'b0, 1'b1);
    step(1'b1, 4'b0010, 1'b0, 1'b1);
    repeat (3) step(1'b0, 4'b0010, 1'b0, 1'b1);

    // Randomised traffic with slowly changing requests and privilege.
    rq = 4'b1111;
    pv = 1'b1;
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) rq[i] = ~rq[i];
      if ($urandom_range(15) == 0) pv = ~pv;
      if ((t % 200) >= 170)
        step(1'b0, rq, pv, 1'b0);
      else
        step(1'b0, rq, pv, $urandom_range(3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
